// File: rtl/mac_pkg.sv
// mac_pkg: shared state type and default parameters for the signed MAC accumulator
package mac_pkg;
    typedef enum logic {ACCUM, HOLD} state_t;
    localparam int N_DEF     = 4;
    localparam int GUARD_DEF = 4;
    localparam int BATCH_DEF = 4;
endpackage

// File: rtl/sat_add_signed.sv
// sat_add_signed: signed adder, clamping on overflow when MAC_ACCUMULATOR_SAT_EN is defined, wrapping otherwise
module sat_add_signed #(
    parameter int ACC_W = 12
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);
    logic signed [ACC_W-1:0] raw;
`ifdef MAC_ACCUMULATOR_SAT_EN
    logic ov;
    // overflow only when both operands share a sign the result does not
    always_comb begin
        raw = a + b;
        ov  = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
        sum = ov ? (a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : raw;
        ovf = ov;
    end
`else
    // plain two's-complement wrap, never flags saturation
    always_comb begin
        raw = a + b;
        sum = raw;
        ovf = 1'b0;
    end
`endif
endmodule

// File: rtl/mac_accumulator_signed.sv
// mac_accumulator_signed: sums BATCH rising-edge products and holds the result until consumed (saturation via MAC_ACCUMULATOR_SAT_EN)
module mac_accumulator_signed
    import mac_pkg::*;
#(
    parameter int n     = N_DEF,
    parameter int GUARD = GUARD_DEF,
    parameter int BATCH = BATCH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [2*n-1:0]       in_product,
    output logic                        in_ready,
    input  logic                        clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [2*n+GUARD-1:0] out_acc,
    output logic                        out_sat,
    output logic                        drop_err
);
    localparam int ACC_W = 2*n+GUARD;
    localparam int CNT_W = $clog2(BATCH+1);

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc, acc_nx, base_acc, prod_ext, add_sum;
    logic [CNT_W-1:0]        cnt, cnt_nx, base_cnt;
    logic                    sat, sat_nx, base_sat, drop, drop_nx, add_ovf;
    logic                    prev_valid, rise, handoff, take;

    assign rise     = in_valid && !prev_valid;
    assign prod_ext = ACC_W'(in_product);

    sat_add_signed #(.ACC_W(ACC_W)) u_add (
        .a  (base_acc),
        .b  (prod_ext),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    // next-state: a handoff restarts from zero so a coincident edge opens the next batch
    always_comb begin
        handoff  = (state == HOLD) && out_ready;
        take     = rise && ((state == ACCUM) || handoff);
        base_acc = handoff ? '0 : acc;
        base_cnt = handoff ? '0 : cnt;
        base_sat = handoff ? 1'b0 : sat;
        acc_nx   = take ? add_sum : base_acc;
        cnt_nx   = take ? base_cnt + CNT_W'(1) : base_cnt;
        sat_nx   = take ? (base_sat | add_ovf) : base_sat;
        state_nx = (take && cnt_nx == CNT_W'(BATCH)) ? HOLD : (handoff ? ACCUM : state);
        drop_nx  = drop | (rise && (state == HOLD) && !out_ready);
        if (clear) begin
            acc_nx   = '0;
            cnt_nx   = '0;
            sat_nx   = 1'b0;
            drop_nx  = 1'b0;
            state_nx = ACCUM;
        end
    end

    // state and datapath registers; edge history tracks in_valid even during clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            drop       <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            cnt        <= cnt_nx;
            sat        <= sat_nx;
            drop       <= drop_nx;
            prev_valid <= in_valid;
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_acc   = acc;
    assign out_sat   = sat;
    assign drop_err  = drop;
endmodule

// File: doc/mac_accumulator_signed.md
MAC_ACCUMULATOR_SIGNED -- requirements
Module: mac_accumulator_signed

Interface
REQ-001 SHALL have parameter n, default 4, operand width of the upstream signed multiplier (product width 2*n).
REQ-002 SHALL have parameter GUARD, default 4, extra accumulator headroom bits; ACC_W = 2*n+GUARD.
REQ-003 SHALL have parameter BATCH, default 4, products summed per output; BATCH >= 1.
REQ-004 SHALL use one clock and an asynchronous active-high reset: clk input 1 rising-edge clock; rst input 1 asynchronous active-high reset.
REQ-005 in_valid  input  1  upstream multiplier valid flag.
REQ-006 in_product  input  signed 2*n  upstream multiplier result.
REQ-007 in_ready  output  1  high when a product will be accepted; upstream gates its enable with it.
REQ-008 clear  input  1  synchronous abort/flush.
REQ-009 out_valid  output  1  batch sum available.
REQ-010 out_ready  input  1  consumer accepts the batch sum.
REQ-011 out_acc  output  signed ACC_W  batch sum.
REQ-012 out_sat  output  1  saturation occurred in this batch.
REQ-013 drop_err  output  1  sticky: a product arrived while not ready.

Function
REQ-014 SHALL accept a product only on the cycle in_valid rises (in_valid=1, previous-cycle in_valid=0); a held-high in_valid counts once.
REQ-015 SHALL have states ACCUM and HOLD; in_ready=1 in ACCUM, 0 in HOLD.
REQ-016 In ACCUM each accepted product SHALL be sign-extended to ACC_W and added to acc; count increments.
REQ-017 On acceptance of the BATCH-th product, next state SHALL be HOLD with out_valid=1 and out_acc equal to the final sum, i.e. 1 cycle latency.
REQ-018 In HOLD, out_acc and out_sat SHALL remain stable until out_valid && out_ready.
REQ-019 On out_valid && out_ready, state SHALL return to ACCUM with acc=0, count=0, out_sat=0 and out_valid=0 the next cycle.
REQ-020 A product edge in the handoff cycle (REQ-019) SHALL start the new batch: acc=product, count=1.
REQ-021 A product edge in HOLD other than the handoff cycle SHALL be discarded and SHALL set drop_err.
REQ-022 clear SHALL have priority over all events, including a simultaneous product or handoff.
REQ-023 clear SHALL zero acc, count, out_valid, out_sat and drop_err, and SHALL force ACCUM.
REQ-024 The edge-detect history register SHALL update every cycle, including cycles where clear is asserted.

Reset
REQ-025 rst SHALL asynchronously force ACCUM, acc=0, count=0, out_valid=0, out_acc=0, out_sat=0, drop_err=0 and edge history=0; in_ready=1 after reset.
REQ-026 rst mid-batch SHALL discard the partial sum without producing an output.

Configuration
REQ-027 With MAC_ACCUMULATOR_SAT_EN defined, overflowing additions SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and set out_sat for the batch.
REQ-028 Without MAC_ACCUMULATOR_SAT_EN, additions SHALL wrap two's-complement and out_sat SHALL be constant 0.

Structure
REQ-029 Package mac_pkg SHALL hold the ACCUM/HOLD state typedef and the default parameter constants.
REQ-030 The saturating/wrapping adder SHALL be a combinational sub-module sat_add_signed, parameterised by ACC_W and controlled by the macro.
REQ-031 The count register width SHALL be clog2(BATCH+1).

Verification (n=4, BATCH=4; GUARD=4 unless noted)
REQ-032 Scenario: pulse products 6, -3, 49, -64 with out_ready=1 -> out_valid 1 cycle after the 4th edge, out_acc = -12, out_sat = 0.
REQ-033 Scenario: in_valid held high 3 cycles with product 10, then 3 single pulses of 1 -> out_acc = 13.
REQ-034 Scenario: GUARD=1, four products of 64 -> with SAT_EN out_acc = 255 and out_sat = 1; without SAT_EN out_acc = -256.
REQ-035 Scenario: out_ready=0 after a batch, a pulse of 5 in HOLD -> drop_err = 1 and out_acc unchanged. Then out_ready=1 with a simultaneous pulse of 7 -> new batch starts with acc = 7, count = 1.
REQ-036 Scenario: two products then clear, then four products of 2 -> out_acc = 8. Repeat with rst asserted mid-batch -> all outputs 0 and no out_valid.
